subleq_ctrl_hs: RTL and testbench

//  Parametrised successor to the fixed-wait SUBLEQ control FSM. Sequences one SUBLEQ

---
 rtl/subleq_ctrl_hs.sv | 161 ++++++++++++++++
 tb/tb_subleq_ctrl_hs.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_ctrl_hs.sv
// SUBLEQ instruction sequencer driving PC/R/MAR/MDR/ALU strobes over the shared bus,
// with req/ack memory handshake, run/step control, halt/timeout handling and retire counter.
module subleq_ctrl_hs #(
    parameter int BRANCH_MODE   = 0,
    parameter int HALT_ON_NEG_C = 1,
    parameter int TIMEOUT       = 255,
    parameter int ICOUNT_W      = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                step,
    input  logic                flag_z,
    input  logic                flag_n,
    input  logic                c_msb,
    input  logic                mem_ack,
    output logic                pc_out,
    output logic                pc_in,
    output logic                pc_inc,
    output logic                r_in,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                read_mem,
    output logic                write_mem,
    output logic                comp_alu,
    output logic                save_flags,
    output logic                busy,
    output logic                halted,
    output logic                mem_err,
    output logic [3:0]          state,
    output logic [ICOUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        A_ADDR = 4'd1,
        A_PRD  = 4'd2,
        A_PMAR = 4'd3,
        A_RD   = 4'd4,
        A_LAT  = 4'd5,
        B_ADDR = 4'd6,
        B_PRD  = 4'd7,
        B_PMAR = 4'd8,
        B_RD   = 4'd9,
        EXEC   = 4'd10,
        WB     = 4'd11,
        C_ADDR = 4'd12,
        C_RD   = 4'd13,
        BRANCH = 4'd14,
        HALT   = 4'd15
    } state_t;

    localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt;
    logic                mem_err_q;
    logic [ICOUNT_W-1:0] count_q;
    logic                in_wait;
    logic                take;
    logic                timed_out;

    always_comb begin
        case (state_q)
            A_PRD, A_RD, B_PRD, B_RD, WB, C_RD: in_wait = 1'b1;
            default:                            in_wait = 1'b0;
        endcase
    end

    // Ack on the cycle the counter reaches TIMEOUT still completes the access
    assign timed_out = (TIMEOUT != 0) && in_wait && !mem_ack
                       && (wait_cnt == WCNT_W'(TIMEOUT));
    assign take      = (BRANCH_MODE != 0) ? flag_n : (flag_z | flag_n);

    always_comb begin
        state_d    = state_q;
        pc_out     = 1'b0;
        pc_in      = 1'b0;
        pc_inc     = 1'b0;
        r_in       = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        read_mem   = 1'b0;
        write_mem  = 1'b0;
        comp_alu   = 1'b0;
        save_flags = 1'b0;
        case (state_q)
            IDLE:   if (run || step) state_d = A_ADDR;
            A_ADDR: begin pc_out = 1'b1; mar_in = 1'b1; state_d = A_PRD; end
            A_PRD:  begin read_mem = 1'b1; if (mem_ack) state_d = A_PMAR; end
            A_PMAR: begin mdr_out = 1'b1; mar_in = 1'b1; state_d = A_RD; end
            A_RD:   begin read_mem = 1'b1; if (mem_ack) state_d = A_LAT; end
            A_LAT:  begin mdr_out = 1'b1; r_in = 1'b1; pc_inc = 1'b1; state_d = B_ADDR; end
            B_ADDR: begin pc_out = 1'b1; mar_in = 1'b1; state_d = B_PRD; end
            B_PRD:  begin read_mem = 1'b1; if (mem_ack) state_d = B_PMAR; end
            B_PMAR: begin mdr_out = 1'b1; mar_in = 1'b1; state_d = B_RD; end
            B_RD:   begin read_mem = 1'b1; if (mem_ack) state_d = EXEC; end
            EXEC: begin
                mdr_out    = 1'b1;
                comp_alu   = 1'b1;
                mdr_in     = 1'b1;
                save_flags = 1'b1;
                state_d    = WB;
            end
            WB: begin
                write_mem = 1'b1;
                if (mem_ack) begin
                    pc_inc  = 1'b1;
                    state_d = C_ADDR;
                end
            end
            C_ADDR: begin pc_out = 1'b1; mar_in = 1'b1; state_d = C_RD; end
            C_RD:   begin read_mem = 1'b1; if (mem_ack) state_d = BRANCH; end
            BRANCH: begin
                if (take && (HALT_ON_NEG_C != 0) && c_msb) begin
                    state_d = HALT;
                end else begin
                    if (take) begin
                        mdr_out = 1'b1;
                        pc_in   = 1'b1;
                    end else begin
                        pc_inc  = 1'b1;
                    end
                    state_d = run ? A_ADDR : IDLE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if (timed_out) state_d = HALT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            // Every wait state is entered from a non-wait state, so a state change clears it
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (in_wait && (TIMEOUT != 0))
                wait_cnt <= wait_cnt + WCNT_W'(1);
            if (timed_out)
                mem_err_q <= 1'b1;
            if (state_q == BRANCH)
                count_q <= count_q + ICOUNT_W'(1);
        end
    end

    assign busy        = (state_q != IDLE) && (state_q != HALT);
    assign halted      = (state_q == HALT);
    assign mem_err     = mem_err_q;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_subleq_ctrl_hs.sv
// Bench for subleq_ctrl_hs: behavioural PC/R/MAR/MDR/ALU/memory around two controllers
// (BRANCH_MODE 0 and 1) in lockstep, with a queue of hand-computed expectations per event.
module tb_subleq_ctrl_hs;

    logic clk, reset_n, run, step, mem_ack;
    logic flag_z, flag_n, c_msb;

    logic pc_out, pc_in, pc_inc, r_in, mar_in, mdr_in, mdr_out;
    logic read_mem, write_mem, comp_alu, save_flags, busy, halted, mem_err;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic pc_out2, pc_in2, pc_inc2, r_in2, mar_in2, mdr_in2, mdr_out2;
    logic read_mem2, write_mem2, comp_alu2, save_flags2, busy2, halted2, mem_err2;
    logic [3:0]  state2;
    logic [31:0] instr_count2;

    subleq_ctrl_hs #(.BRANCH_MODE(0), .HALT_ON_NEG_C(1), .TIMEOUT(8), .ICOUNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step),
        .flag_z(flag_z), .flag_n(flag_n), .c_msb(c_msb), .mem_ack(mem_ack),
        .pc_out(pc_out), .pc_in(pc_in), .pc_inc(pc_inc), .r_in(r_in), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .read_mem(read_mem), .write_mem(write_mem),
        .comp_alu(comp_alu), .save_flags(save_flags), .busy(busy), .halted(halted),
        .mem_err(mem_err), .state(state), .instr_count(instr_count)
    );

    subleq_ctrl_hs #(.BRANCH_MODE(1), .HALT_ON_NEG_C(1), .TIMEOUT(8), .ICOUNT_W(32)) dut2 (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step),
        .flag_z(flag_z), .flag_n(flag_n), .c_msb(c_msb), .mem_ack(mem_ack),
        .pc_out(pc_out2), .pc_in(pc_in2), .pc_inc(pc_inc2), .r_in(r_in2), .mar_in(mar_in2),
        .mdr_in(mdr_in2), .mdr_out(mdr_out2), .read_mem(read_mem2), .write_mem(write_mem2),
        .comp_alu(comp_alu2), .save_flags(save_flags2), .busy(busy2), .halted(halted2),
        .mem_err(mem_err2), .state(state2), .instr_count(instr_count2)
    );

    logic [10:0] strb1, strb2;
    assign strb1 = {pc_out, pc_in, pc_inc, r_in, mar_in, mdr_in, mdr_out,
                    read_mem, write_mem, comp_alu, save_flags};
    assign strb2 = {pc_out2, pc_in2, pc_inc2, r_in2, mar_in2, mdr_in2, mdr_out2,
                    read_mem2, write_mem2, comp_alu2, save_flags2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath and memory model, driven by the BRANCH_MODE=0 controller
    logic [15:0] mem [0:255];
    logic [15:0] pc, r, mar, mdr, bus, alu;
    logic        fz, fn;

    assign flag_z = fz;
    assign flag_n = fn;
    assign c_msb  = mdr[15];
    assign bus    = pc_out ? pc : (mdr_out ? mdr : 16'h0000);
    assign alu    = bus - r;

    initial begin
        fz = 1'b0;
        fn = 1'b0;
    end

    always @(posedge clk) begin
        if (mar_in) mar <= bus;
        if (r_in)   r   <= bus;
        if (pc_in)       pc <= bus;
        else if (pc_inc) pc <= pc + 16'd1;
        if (read_mem && mem_ack) mdr <= mem[mar[7:0]];
        if (comp_alu && mdr_in)  mdr <= alu;
        if (save_flags) begin
            fz <= (alu == 16'h0000);
            fn <= alu[15];
        end
        if (write_mem && mem_ack) mem[mar[7:0]] <= mdr;
    end

    // Memory responder: latency 0 everywhere except lat_sp cycles in lat_state
    logic [3:0] lat_state;
    int         lat_sp;
    int         acc;
    initial begin
        mem_ack = 1'b0;
        acc     = 0;
    end
    always @(negedge clk) begin
        if (read_mem || write_mem) begin
            mem_ack = (acc >= ((state == lat_state) ? lat_sp : 0));
            acc++;
        end else begin
            mem_ack = 1'b0;
            acc     = 0;
        end
    end

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  addr;
        logic [15:0] val;
        logic [31:0] cnt;
        logic [3:0]  st;
        logic [10:0] strb;
        logic        busy;
        logic        halted;
        logic        merr;
        bit          timing;
        int          cyc;
        int          brd;
        logic [1:0]  br2;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks, errors;
    bit   snap;

    task automatic push(input logic [15:0] p, input logic [7:0] a, input logic [15:0] v,
                        input logic [31:0] c, input logic [3:0] st, input logic [10:0] sb,
                        input logic b, input logic h, input logic m, input bit tm,
                        input int cyc, input int brd, input logic [1:0] b2);
        exp_t x;
        x.pc = p; x.addr = a; x.val = v; x.cnt = c; x.st = st; x.strb = sb;
        x.busy = b; x.halted = h; x.merr = m; x.timing = tm;
        x.cyc = cyc; x.brd = brd; x.br2 = b2;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: events are a retirement, entry into HALT, or a snapshot request
    logic [31:0] prev_cnt;
    logic        prev_halt;
    int          ic, brd;
    logic [1:0]  br2;
    initial begin
        prev_cnt = 32'd0; prev_halt = 1'b0; ic = 0; brd = 0; br2 = 2'b00;
        checks = 0; errors = 0; snap = 1'b0;
    end

    always @(negedge clk) begin
        if ((instr_count == prev_cnt + 32'd1) || (halted && !prev_halt) || snap) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event count=%0d state=%0d expected none", instr_count, state);
            end else begin
                e = exp_q.pop_front();
                chk("pc", {16'h0, pc}, {16'h0, e.pc});
                chk("mem_b", {16'h0, mem[e.addr]}, {16'h0, e.val});
                chk("count", instr_count, e.cnt);
                chk("state", {28'h0, state}, {28'h0, e.st});
                chk("strobes", {21'h0, strb1}, {21'h0, e.strb});
                chk("busy", {31'h0, busy}, {31'h0, e.busy});
                chk("halted", {31'h0, halted}, {31'h0, e.halted});
                chk("mem_err", {31'h0, mem_err}, {31'h0, e.merr});
                chk("count2", instr_count2, e.cnt);
                chk("state2", {28'h0, state2}, {28'h0, e.st});
                chk("strobes2", {21'h0, strb2}, {21'h0, e.strb});
                chk("busy2", {31'h0, busy2}, {31'h0, e.busy});
                chk("halted2", {31'h0, halted2}, {31'h0, e.halted});
                chk("mem_err2", {31'h0, mem_err2}, {31'h0, e.merr});
                if (e.timing) begin
                    chk("cycles", ic, e.cyc);
                    chk("b_rd_cycles", brd, e.brd);
                    chk("branch_mode1", {30'h0, br2}, {30'h0, e.br2});
                end
            end
            snap = 1'b0;
        end
        prev_cnt  = instr_count;
        prev_halt = halted;
        if (state == 4'd1) ic = 1; else if (busy) ic++;
        if (state == 4'd1) brd = 0; else if (state == 4'd9 && read_mem) brd++;
        if (state2 == 4'd1) br2 = 2'b00; else if (state2 == 4'd14) br2 = {pc_in2, pc_inc2};
    end

    task automatic wait_state(input logic [3:0] s, input int bound, input string nm);
        int n;
        n = 0;
        while (state !== s && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (state !== s) begin
            errors++;
            $display("FAIL %s state %0d expected %0d within %0d cycles", nm, state, s, bound);
        end
    endtask

    task automatic wait_count(input logic [31:0] c, input int bound, input string nm);
        int n;
        n = 0;
        while (instr_count !== c && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (instr_count !== c) begin
            errors++;
            $display("FAIL %s count %0d expected %0d within %0d cycles", nm, instr_count, c, bound);
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; step = 1'b0;
        lat_state = 4'd0; lat_sp = 0;
        pc <= 16'd0;
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        mem[0]  <= 16'd100; mem[1]  <= 16'd101; mem[2]  <= 16'd20;
        mem[100] <= 16'd3;  mem[101] <= 16'd5;
        mem[3]  <= 16'd102; mem[4]  <= 16'd103; mem[5]  <= 16'd40;
        mem[102] <= 16'd5;  mem[103] <= 16'd5;
        mem[40] <= 16'd104; mem[41] <= 16'd105; mem[42] <= 16'd50;
        mem[104] <= 16'd1;  mem[105] <= 16'd7;
        mem[43] <= 16'd106; mem[44] <= 16'd107; mem[45] <= 16'd60;
        mem[106] <= 16'd2;  mem[107] <= 16'd2;
        mem[60] <= 16'd108; mem[61] <= 16'd109; mem[62] <= 16'd70;
        mem[108] <= 16'd9;  mem[109] <= 16'd4;
        mem[70] <= 16'd110; mem[71] <= 16'd111; mem[72] <= 16'h8000;
        mem[110] <= 16'd2;  mem[111] <= 16'd1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        push(16'd0, 8'd101, 16'd5, 32'd0, 4'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'b00);
        snap = 1'b1;
        @(posedge clk); #1;

        // 5-3=2, no branch; run dropped mid-instruction
        push(16'd3, 8'd101, 16'd2, 32'd1, 4'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 14, 1, 2'b01);
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        wait_state(4'd0, 100, "single_run");

        // Continuous run: 5-5=0 branches to 40 in mode 0 only, then 7-1=6 falls through
        push(16'd40, 8'd103, 16'd0, 32'd2, 4'd1, 11'h440, 1'b1, 1'b0, 1'b0, 1'b1, 14, 1, 2'b01);
        push(16'd43, 8'd105, 16'd6, 32'd3, 4'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 14, 1, 2'b01);
        run = 1'b1;
        wait_count(32'd2, 100, "continuous_run");
        repeat (2) @(posedge clk);
        #1 run = 1'b0;
        wait_state(4'd0, 100, "run_drop");

        // Step with 4-cycle ack delay on B_RD
        lat_state = 4'd9; lat_sp = 4;
        push(16'd60, 8'd107, 16'd0, 32'd4, 4'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 18, 5, 2'b01);
        pulse_step();
        wait_state(4'd0, 100, "delayed_ack");
        lat_sp = 0;

        // 4-9=-5 taken in both modes
        push(16'd70, 8'd109, 16'hFFFB, 32'd5, 4'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 14, 1, 2'b10);
        pulse_step();
        wait_state(4'd0, 100, "negative_branch");

        // 1-2=-1 with C=0x8000 halts, PC stays at 72
        push(16'd72, 8'd111, 16'hFFFF, 32'd6, 4'd15, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 14, 1, 2'b00);
        pulse_step();
        wait_state(4'd15, 100, "halt_neg_c");
        pulse_step();
        repeat (3) @(posedge clk);
        #1;
        push(16'd72, 8'd111, 16'hFFFF, 32'd6, 4'd15, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2'b00);
        snap = 1'b1;
        @(posedge clk); #1;

        // No ack in A_PRD with TIMEOUT=8: 9 wait cycles then HALT with mem_err
        reset_n = 1'b0;
        pc <= 16'd0;
        lat_state = 4'd2; lat_sp = 32'h7FFF_FFFF;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        push(16'd0, 8'd101, 16'd2, 32'd0, 4'd15, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 10, 0, 2'b00);
        pulse_step();
        wait_state(4'd15, 100, "timeout");

        // Reset while WB waits for ack: no write reaches memory
        reset_n = 1'b0;
        pc <= 16'd0;
        lat_state = 4'd11; lat_sp = 3;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        pulse_step();
        wait_state(4'd11, 100, "reach_wb");
        do_reset();
        push(16'd1, 8'd101, 16'd2, 32'd0, 4'd0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2'b00);
        snap = 1'b1;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
